// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, control tokens and the aligner state type.
// Imported by both the encoder and decoder sides of the link.
package tmds_pkg;

    localparam int unsigned SYMBOL_WIDTH = 10;

    // Control tokens as they appear on the wire (bit 0 transmitted first).
    localparam logic [SYMBOL_WIDTH-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [SYMBOL_WIDTH-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [SYMBOL_WIDTH-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [SYMBOL_WIDTH-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        StSearch,
        StSlip,
        StSettle,
        StLocked
    } align_state_e;

    // Largest of three values; sizes the shared cycle timer.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol classifier and 10b-to-8b data decoder.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYMBOL_WIDTH-1:0] i_word,
    output logic                    o_is_ctrl,
    output logic [1:0]              o_ctrl,
    output logic [7:0]              o_data
);

    logic [7:0] w_d;

    // Match the four control tokens; anything else is a data symbol.
    always_comb begin
        o_is_ctrl = 1'b1;
        o_ctrl    = 2'b00;
        case (i_word)
            CTRL_TOKEN_00: o_ctrl = 2'b00;
            CTRL_TOKEN_01: o_ctrl = 2'b01;
            CTRL_TOKEN_10: o_ctrl = 2'b10;
            CTRL_TOKEN_11: o_ctrl = 2'b11;
            default:       o_is_ctrl = 1'b0;
        endcase
    end

    // Undo the optional inversion (q[9]) then the XOR/XNOR chain (q[8] selects XOR).
    always_comb begin
        w_d       = i_word[9] ? ~i_word[7:0] : i_word[7:0];
        o_data    = '0;
        o_data[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            o_data[i] = i_word[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel: word-alignment FSM driving the deserializer bitslip, lock
// tracking on control-token runs, and registered video outputs.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_COUNT     = 16,
    parameter int unsigned SEARCH_TIMEOUT = 4096,
    parameter int unsigned SLIP_WAIT      = 8,
    parameter int unsigned LOSS_TIMEOUT   = 16384
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SYMBOL_WIDTH-1:0] tmds_word,
    output logic                    bitslip,
    output logic                    locked,
    output logic [3:0]              align_phase,
    output logic                    video_de,
    output logic [1:0]              video_ctrl,
    output logic [7:0]              video_data
);

    localparam int unsigned TIMER_MAX = max3(SEARCH_TIMEOUT, SLIP_WAIT, LOSS_TIMEOUT);
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int unsigned RUN_W     = $clog2(LOCK_COUNT + 1);

    localparam logic [TIMER_W-1:0] SEARCH_LAST = TIMER_W'(SEARCH_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SLIP_WAIT - 1);
    localparam logic [TIMER_W-1:0] LOSS_LAST   = TIMER_W'(LOSS_TIMEOUT - 1);
    localparam logic [RUN_W-1:0]   RUN_FULL    = RUN_W'(LOCK_COUNT);

    align_state_e            r_state, w_state_next;
    logic [TIMER_W-1:0]      r_timer, w_timer_next, w_timer_inc;
    logic [RUN_W-1:0]        r_run_cnt, w_run_next, w_run_track;
    logic [SYMBOL_WIDTH-1:0] r_prev_word, w_prev_next;
    logic                    w_run_full;

    logic       r_bitslip, w_bitslip_next;
    logic       r_locked, w_locked_next;
    logic [3:0] r_align_phase, w_align_next;
    logic       r_video_de, w_de_next;
    logic [1:0] r_video_ctrl, w_ctrl_next;
    logic [7:0] r_video_data, w_data_next;

    logic       w_is_ctrl;
    logic [1:0] w_ctrl;
    logic [7:0] w_data;

    tmds_symbol_decode u_symbol_decode (
        .i_word    (tmds_word),
        .o_is_ctrl (w_is_ctrl),
        .o_ctrl    (w_ctrl),
        .o_data    (w_data)
    );

    // Saturating token-run length and cycle timer as seen by this word.
    always_comb begin
        w_timer_inc = (r_timer == '1) ? r_timer : r_timer + TIMER_W'(1);
        if (!w_is_ctrl) begin
            w_run_track = '0;
        end else if (tmds_word == r_prev_word) begin
            w_run_track = (r_run_cnt == RUN_FULL) ? r_run_cnt : r_run_cnt + RUN_W'(1);
        end else begin
            w_run_track = RUN_W'(1);
        end
        w_run_full = (w_run_track == RUN_FULL);
    end

    // Aligner next-state: one timer serves search timeout, settle wait and loss timeout.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_run_next   = r_run_cnt;
        w_prev_next  = r_prev_word;
        unique case (r_state)
            StSearch: begin
                w_prev_next = tmds_word;
                w_run_next  = w_run_track;
                // Lock takes priority over a coincident timeout.
                if (w_run_full) begin
                    w_state_next = StLocked;
                    w_timer_next = '0;
                end else if (r_timer == SEARCH_LAST) begin
                    w_state_next = StSlip;
                    w_timer_next = '0;
                    w_run_next   = '0;
                    w_prev_next  = '0;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            StSlip: begin
                w_state_next = StSettle;
                w_timer_next = '0;
                w_run_next   = '0;
                w_prev_next  = '0;
            end
            StSettle: begin
                // Deserializer output is untrustworthy here, so keep everything cleared.
                w_run_next  = '0;
                w_prev_next = '0;
                if (r_timer == SETTLE_LAST) begin
                    w_state_next = StSearch;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            StLocked: begin
                w_prev_next = tmds_word;
                w_run_next  = w_run_track;
                if (w_run_full) begin
                    w_timer_next = '0;
                end else if (r_timer == LOSS_LAST) begin
                    w_state_next = StSearch;
                    w_timer_next = '0;
                    w_run_next   = '0;
                    w_prev_next  = '0;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            default: begin
                w_state_next = StSearch;
                w_timer_next = '0;
                w_run_next   = '0;
                w_prev_next  = '0;
            end
        endcase
    end

    // Output next values; gating on the next lock state keeps video zero whenever locked is 0.
    always_comb begin
        w_locked_next  = (w_state_next == StLocked);
        w_bitslip_next = (w_state_next == StSlip);
        w_align_next   = r_align_phase;
        if (w_bitslip_next) begin
            w_align_next = (r_align_phase == 4'd9) ? 4'd0 : r_align_phase + 4'd1;
        end
        w_de_next   = 1'b0;
        w_ctrl_next = r_video_ctrl;
        w_data_next = '0;
        if (!w_locked_next) begin
            w_ctrl_next = '0;
        end else if (w_is_ctrl) begin
            w_ctrl_next = w_ctrl;
        end else begin
            w_de_next   = 1'b1;
            w_data_next = w_data;
        end
    end

    // FSM state and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StSearch;
            r_timer     <= '0;
            r_run_cnt   <= '0;
            r_prev_word <= '0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_run_cnt   <= w_run_next;
            r_prev_word <= w_prev_next;
        end
    end

    // Registered status and video outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bitslip     <= 1'b0;
            r_locked      <= 1'b0;
            r_align_phase <= '0;
            r_video_de    <= 1'b0;
            r_video_ctrl  <= '0;
            r_video_data  <= '0;
        end else begin
            r_bitslip     <= w_bitslip_next;
            r_locked      <= w_locked_next;
            r_align_phase <= w_align_next;
            r_video_de    <= w_de_next;
            r_video_ctrl  <= w_ctrl_next;
            r_video_data  <= w_data_next;
        end
    end

    assign bitslip     = r_bitslip;
    assign locked      = r_locked;
    assign align_phase = r_align_phase;
    assign video_de    = r_video_de;
    assign video_ctrl  = r_video_ctrl;
    assign video_data  = r_video_data;

endmodule

// File: doc/tmds_channel_decoder.md
TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 The parameter LOCK_COUNT SHALL default to 16 and sets the number of consecutive identical control tokens required to declare lock.
REQ-002 The parameter SEARCH_TIMEOUT SHALL default to 4096 and sets the number of cycles without lock before one bitslip is issued.
REQ-003 The parameter SLIP_WAIT SHALL default to 8 and sets the number of cycles ignored after a bitslip, covering deserializer settling.
REQ-004 The parameter LOSS_TIMEOUT SHALL default to 16384 and sets the number of cycles in LOCKED without a qualifying token run before lock is dropped.
REQ-005 Port clock SHALL be an input, 1 bit wide: the pixel clock; one clock domain; every flop samples on its rising edge.
REQ-006 Port reset SHALL be an input, 1 bit wide: synchronous, active-high.
REQ-007 Port tmds_word SHALL be an input, 10 bits wide: the parallel symbol from the deserializer, valid every cycle, bit 0 first on the wire.
REQ-008 Port bitslip SHALL be an output, 1 bit wide: a one-cycle pulse that requests a one-bit word shift from the deserializer.
REQ-009 Port locked SHALL be an output, 1 bit wide: high when symbol alignment is established.
REQ-010 Port align_phase SHALL be an output, 4 bits wide: the count of bitslips issued, 0..9, wrapping from 9 to 0.
REQ-011 Port video_de SHALL be an output, 1 bit wide: data enable, high for a data symbol.
REQ-012 Port video_ctrl SHALL be an output, 2 bits wide: {c1,c0} taken from the last control token.
REQ-013 Port video_data SHALL be an output, 8 bits wide: the decoded pixel component.

Function
REQ-014 Control tokens SHALL be recognized as follows: 10'b1101010100 is ctrl 00, 10'b0010101011 is ctrl 01, 10'b0101010100 is ctrl 10, and 10'b1010101011 is ctrl 11; every other word is a data symbol.
REQ-015 Data decode SHALL first form d = q[9] ? ~q[7:0] : q[7:0], then produce out[0] = d[0] and, for i = 1..7, out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-016 Outputs SHALL be registered, with a latency of exactly 1 cycle from tmds_word to video_de, video_ctrl and video_data.
REQ-017 A control token SHALL produce video_de=0, video_ctrl=token value and video_data=0.
REQ-018 A data symbol SHALL produce video_de=1, video_data=decoded value, and video_ctrl holding its previous value.
REQ-019 While locked=0, the outputs SHALL be forced to video_de=0, video_ctrl=0 and video_data=0.
REQ-020 The FSM SHALL have the states SEARCH, SLIP, SETTLE and LOCKED.
REQ-021 In SEARCH, run_cnt SHALL increment on a control token equal to the previous word and reset to 1 on any other control token; a data symbol SHALL reset it to 0.
REQ-022 In SEARCH, when run_cnt reaches LOCK_COUNT the FSM SHALL go to LOCKED, and locked SHALL go high in the same edge.
REQ-023 In SEARCH, when the timeout counter reaches SEARCH_TIMEOUT-1 without lock, the FSM SHALL go to SLIP.
REQ-024 In SEARCH, if the lock condition and the timeout occur in the same cycle, lock SHALL win.
REQ-025 SLIP SHALL last 1 cycle: bitslip=1, align_phase advances (9 wraps to 0), then the FSM goes to SETTLE.
REQ-026 SETTLE SHALL last SLIP_WAIT cycles, during which input is ignored and counters are cleared; the FSM then returns to SEARCH.
REQ-027 In LOCKED, each run of at least LOCK_COUNT consecutive identical tokens SHALL restart the loss counter.
REQ-028 In LOCKED, when the loss counter reaches LOSS_TIMEOUT-1, the FSM SHALL go to SEARCH with locked=0; align_phase SHALL be retained.
REQ-029 Counters SHALL saturate and never wrap, except align_phase.
REQ-030 bitslip SHALL never be asserted in two consecutive cycles, and SHALL be asserted only in SLIP.

Reset
REQ-031 Reset SHALL apply state=SEARCH, bitslip=0, locked=0, align_phase=0, video_de=0, video_ctrl=0, video_data=0, and all counters=0.
REQ-032 Reset asserted mid-SLIP or mid-SETTLE SHALL take effect on the next edge, with no further bitslip pulse.

Structure
REQ-033 Package tmds_pkg SHALL hold the four control-token constants, the FSM state enum, and the shared symbol width constant (10); the existing encoder side SHALL import it too.
REQ-034 The combinational sub-module tmds_symbol_decode SHALL classify a word and decode it (is_ctrl, ctrl[1:0], data[7:0]); the aligner FSM, counters and output registers SHALL live in tmds_channel_decoder.

Verification
REQ-035 Reset, then 16 cycles of 10'b1101010100 -> locked=1 after the 16th word, video_ctrl=00, video_de=0, bitslip never pulsed.
REQ-036 Locked, then drive 10'h100 and 10'h3FF -> video_data=8'h00 for each, video_de=1, each one cycle after its input.
REQ-037 A token stream rotated by 3 bits, with a model that rotates the stream back one bit per bitslip -> 3 slips spaced SEARCH_TIMEOUT+SLIP_WAIT+1 cycles apart, then lock with align_phase=3.
REQ-038 Random non-token data for 12 slip periods -> align_phase sequence 1..9,0,1,2 and locked stays 0.
REQ-039 Locked, then data-only input for LOSS_TIMEOUT cycles -> locked falls and outputs are zeroed the next cycle; a 15-token run before the timeout does not prevent the loss.
REQ-040 Reset asserted during the SLIP cycle -> the next cycle shows bitslip=0, state SEARCH and align_phase=0.
